// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared definitions for the branch resolve controller.
//   F3_*        : RV32I branch funct3 encodings
//   br_state_t  : controller FSM state
package branch_resolve_ctrl_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    StIdle,
    StResolve,
    StRedirect,
    StFlush
  } br_state_t;

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// Decode -> branch resolve request channel.
//   br_valid/br_ready : handshake, transfer accepted when both high on a rising edge
//   br_funct3         : branch condition (ignored for jumps)
//   br_is_jump        : JAL/JALR, unconditionally taken
//   br_base_sel       : 0 target base is br_pc, 1 base is br_rs1
//   br_pc/rs1/imm     : operands for target computation
// Modports: master = decode side, slave = branch resolve controller.
interface branch_resolve_ctrl_if #(
  parameter int unsigned N = 32
) ();

  logic         br_valid;
  logic         br_ready;
  logic [2:0]   br_funct3;
  logic         br_is_jump;
  logic         br_base_sel;
  logic [N-1:0] br_pc;
  logic [N-1:0] br_rs1;
  logic [N-1:0] br_imm;

  modport master (
    output br_valid, br_funct3, br_is_jump, br_base_sel, br_pc, br_rs1, br_imm,
    input  br_ready
  );

  modport slave (
    input  br_valid, br_funct3, br_is_jump, br_base_sel, br_pc, br_rs1, br_imm,
    output br_ready
  );

endinterface

// File: rtl/branch_resolve_ctrl_cond_eval.sv
// Combinational branch condition evaluator.
//   funct3_i  : branch funct3
//   is_jump_i : jump, forces taken and never illegal
//   br_eq_i   : comparator equal result
//   br_lt_i   : comparator less-than result
//   taken_o   : transfer is taken
//   illegal_o : funct3 is not a valid branch encoding (010/011)
module branch_resolve_ctrl_cond_eval
  import branch_resolve_ctrl_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       is_jump_i,
  input  logic       br_eq_i,
  input  logic       br_lt_i,
  output logic       taken_o,
  output logic       illegal_o
);

  always_comb begin
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    if (is_jump_i) begin
      taken_o = 1'b1;
    end else begin
      case (funct3_i)
        F3_BEQ:           taken_o = br_eq_i;
        F3_BNE:           taken_o = ~br_eq_i;
        F3_BLT, F3_BLTU:  taken_o = br_lt_i;
        F3_BGE, F3_BGEU:  taken_o = ~br_lt_i;
        default:          illegal_o = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch/jump resolve controller: accepts one control transfer from decode, evaluates
// the comparator result, issues a one-cycle PC redirect and then holds flush.
//   clk, rst_n      : clock, asynchronous active-low reset
//   br_if           : decode request channel (slave)
//   BrUn            : unsigned compare select to branch_comp (RESOLVE only)
//   BrEq, BrLT      : comparator results
//   redirect_valid  : one-cycle fetch redirect pulse
//   redirect_pc     : redirect target, holds last target between redirects
//   misalign        : target not word aligned, qualified by redirect_valid
//   illegal_br      : reserved branch funct3 seen in RESOLVE
//   flush           : kill younger instructions (REDIRECT + FLUSH_CYCLES)
//   taken_count     : saturating count of redirects
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int unsigned N            = 32,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  branch_resolve_ctrl_if.slave br_if,
  output logic                 BrUn,
  input  logic                 BrEq,
  input  logic                 BrLT,
  output logic                 redirect_valid,
  output logic [N-1:0]         redirect_pc,
  output logic                 misalign,
  output logic                 illegal_br,
  output logic                 flush,
  output logic [CNT_W-1:0]     taken_count
);

  localparam int unsigned FcW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  // Load value for the flush down-counter; unused when FLUSH_CYCLES is 0.
  localparam logic [FcW-1:0] FcLoad = FcW'(FLUSH_CYCLES - 1);

  br_state_t      state_q, state_d;
  logic [2:0]     funct3_q, funct3_d;
  logic           is_jump_q, is_jump_d;
  logic [N-1:0]   target_q, target_d;
  logic [N-1:0]   redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FcW-1:0] fcnt_q, fcnt_d;

  logic           taken;
  logic           illegal;
  logic [N-1:0]   new_target;

  branch_resolve_ctrl_cond_eval u_cond_eval (
    .funct3_i  (funct3_q),
    .is_jump_i (is_jump_q),
    .br_eq_i   (BrEq),
    .br_lt_i   (BrLT),
    .taken_o   (taken),
    .illegal_o (illegal)
  );

  // JALR clears bit 0 of the sum; JAL and branches keep the raw sum.
  always_comb begin
    new_target = (br_if.br_base_sel ? br_if.br_rs1 : br_if.br_pc) + br_if.br_imm;
    if (br_if.br_is_jump && br_if.br_base_sel) begin
      new_target[0] = 1'b0;
    end
  end

  always_comb begin
    state_d        = state_q;
    funct3_d       = funct3_q;
    is_jump_d      = is_jump_q;
    target_d       = target_q;
    redirect_pc_d  = redirect_pc_q;
    cnt_d          = cnt_q;
    fcnt_d         = fcnt_q;
    br_if.br_ready = 1'b0;
    BrUn           = 1'b0;
    redirect_valid = 1'b0;
    misalign       = 1'b0;
    illegal_br     = 1'b0;
    flush          = 1'b0;

    unique case (state_q)
      StIdle: begin
        br_if.br_ready = 1'b1;
        if (br_if.br_valid) begin
          funct3_d  = br_if.br_funct3;
          is_jump_d = br_if.br_is_jump;
          target_d  = new_target;
          state_d   = StResolve;
        end
      end
      StResolve: begin
        // funct3[1] distinguishes BLTU/BGEU from BLT/BGE.
        BrUn       = is_jump_q ? 1'b0 : funct3_q[1];
        illegal_br = illegal;
        if (taken) begin
          redirect_pc_d = target_q;
          state_d       = StRedirect;
        end else begin
          state_d = StIdle;
        end
      end
      StRedirect: begin
        redirect_valid = 1'b1;
        misalign       = |redirect_pc_q[1:0];
        flush          = 1'b1;
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (FLUSH_CYCLES == 0) begin
          state_d = StIdle;
        end else begin
          fcnt_d  = FcLoad;
          state_d = StFlush;
        end
      end
      StFlush: begin
        flush = 1'b1;
        if (fcnt_q == '0) begin
          state_d = StIdle;
        end else begin
          fcnt_d = fcnt_q - FcW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      funct3_q      <= '0;
      is_jump_q     <= 1'b0;
      target_q      <= '0;
      redirect_pc_q <= '0;
      cnt_q         <= '0;
      fcnt_q        <= '0;
    end else begin
      state_q       <= state_d;
      funct3_q      <= funct3_d;
      is_jump_q     <= is_jump_d;
      target_q      <= target_d;
      redirect_pc_q <= redirect_pc_d;
      cnt_q         <= cnt_d;
      fcnt_q        <= fcnt_d;
    end
  end

  assign redirect_pc = redirect_pc_q;
  assign taken_count = cnt_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
module tb_branch_resolve_ctrl;
  import branch_resolve_ctrl_pkg::*;

  localparam int unsigned N  = 32;
  localparam int unsigned FC = 2;
  localparam int unsigned CW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main DUT: default parameters
  branch_resolve_ctrl_if #(.N(N)) bif ();
  logic          br_un, br_eq, br_lt, rv, mis, ill, fl;
  logic [N-1:0]  rpc;
  logic [CW-1:0] tcnt;

  branch_resolve_ctrl #(.N(N), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .br_if          (bif),
    .BrUn           (br_un),
    .BrEq           (br_eq),
    .BrLT           (br_lt),
    .redirect_valid (rv),
    .redirect_pc    (rpc),
    .misalign       (mis),
    .illegal_br     (ill),
    .flush          (fl),
    .taken_count    (tcnt)
  );

  // Second DUT: 2-bit counter, no FLUSH state
  branch_resolve_ctrl_if #(.N(N)) bif2 ();
  logic         br_un2, br_eq2, br_lt2, rv2, mis2, ill2, fl2;
  logic [N-1:0] rpc2;
  logic [1:0]   tcnt2;

  branch_resolve_ctrl #(.N(N), .FLUSH_CYCLES(0), .CNT_W(2)) dut2 (
    .clk            (clk),
    .rst_n          (rst_n),
    .br_if          (bif2),
    .BrUn           (br_un2),
    .BrEq           (br_eq2),
    .BrLT           (br_lt2),
    .redirect_valid (rv2),
    .redirect_pc    (rpc2),
    .misalign       (mis2),
    .illegal_br     (ill2),
    .flush          (fl2),
    .taken_count    (tcnt2)
  );

  typedef struct packed {
    logic [N-1:0] pc;
    logic         mis;
  } exp_t;

  exp_t         sb_q[$];
  int           total = 0;
  int           bad = 0;
  int unsigned  cnt_model = 0;
  logic [N-1:0] last_pc = '0;

  function automatic logic [N-1:0] calc_target(input logic jump, input logic sel,
                                               input logic [N-1:0] pc, input logic [N-1:0] rs1,
                                               input logic [N-1:0] imm);
    logic [N-1:0] t;
    t = (sel ? rs1 : pc) + imm;
    if (jump && sel) t[0] = 1'b0;
    return t;
  endfunction

  task automatic wait_ready(input string name, output logic ok);
    int n;
    n = 0;
    while (bif.br_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = (bif.br_ready === 1'b1);
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL %s: br_ready timeout, got %b want 1", name, bif.br_ready);
    end
  endtask

  // One full transaction on the main DUT with per-cycle checks.
  task automatic issue(input string name, input logic [2:0] f3, input logic jump,
                       input logic sel, input logic [N-1:0] pc, input logic [N-1:0] rs1,
                       input logic [N-1:0] imm, input logic eq, input logic lt,
                       input logic exp_taken, input logic exp_brun, input logic exp_ill);
    logic ok;
    exp_t e;
    exp_t got;
    wait_ready(name, ok);
    if (!ok) return;
    bif.br_funct3   = f3;
    bif.br_is_jump  = jump;
    bif.br_base_sel = sel;
    bif.br_pc       = pc;
    bif.br_rs1      = rs1;
    bif.br_imm      = imm;
    br_eq           = eq;
    br_lt           = lt;
    bif.br_valid    = 1'b1;
    if (exp_taken) begin
      e.pc  = calc_target(jump, sel, pc, rs1, imm);
      e.mis = |e.pc[1:0];
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1 bif.br_valid = 1'b0;
    @(negedge clk);  // RESOLVE
    total++;
    if ({br_un, ill, rv, bif.br_ready} !== {exp_brun, exp_ill, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL %s resolve: {BrUn,illegal,rv,ready} got %b want %b", name,
               {br_un, ill, rv, bif.br_ready}, {exp_brun, exp_ill, 1'b0, 1'b0});
    end
    @(negedge clk);  // cycle k+2
    if (exp_taken) begin
      total++;
      if ({rv, fl, br_un, ill} !== 4'b1100) begin
        bad++;
        $display("FAIL %s redirect: {rv,flush,BrUn,illegal} got %b want 1100", name,
                 {rv, fl, br_un, ill});
      end
      if (rv === 1'b1) begin
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL %s scoreboard: redirect with empty queue, pc %h", name, rpc);
        end else begin
          got = sb_q.pop_front();
          if ({rpc, mis} !== {got.pc, got.mis}) begin
            bad++;
            $display("FAIL %s target: pc/mis got %h/%b want %h/%b", name, rpc, mis,
                     got.pc, got.mis);
          end
          last_pc = got.pc;
        end
      end
      cnt_model++;
      for (int i = 0; i < int'(FC); i++) begin
        @(negedge clk);
        total++;
        if ({fl, bif.br_ready, rv} !== 3'b100) begin
          bad++;
          $display("FAIL %s flush%0d: {flush,ready,rv} got %b want 100", name, i,
                   {fl, bif.br_ready, rv});
        end
      end
      @(negedge clk);
      total++;
      if ({fl, bif.br_ready} !== 2'b01) begin
        bad++;
        $display("FAIL %s done: {flush,ready} got %b want 01", name, {fl, bif.br_ready});
      end
    end else begin
      total++;
      if ({rv, fl, bif.br_ready, br_un} !== 4'b0010) begin
        bad++;
        $display("FAIL %s not-taken: {rv,flush,ready,BrUn} got %b want 0010", name,
                 {rv, fl, bif.br_ready, br_un});
      end
      total++;
      if (rpc !== last_pc) begin
        bad++;
        $display("FAIL %s pc hold: redirect_pc got %h want %h", name, rpc, last_pc);
      end
    end
    total++;
    if (tcnt !== CW'(cnt_model)) begin
      bad++;
      $display("FAIL %s count: taken_count got %0d want %0d", name, tcnt, cnt_model);
    end
  endtask

  task automatic test_reset();
    bif.br_valid = 1'b0; bif.br_funct3 = '0; bif.br_is_jump = 1'b0; bif.br_base_sel = 1'b0;
    bif.br_pc = '0; bif.br_rs1 = '0; bif.br_imm = '0;
    bif2.br_valid = 1'b0; bif2.br_funct3 = '0; bif2.br_is_jump = 1'b0; bif2.br_base_sel = 1'b0;
    bif2.br_pc = '0; bif2.br_rs1 = '0; bif2.br_imm = '0;
    br_eq = 1'b0; br_lt = 1'b0; br_eq2 = 1'b0; br_lt2 = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({bif.br_ready, rv, fl, br_un, ill, mis} !== 6'b100000) begin
      bad++;
      $display("FAIL reset outputs: {ready,rv,flush,BrUn,ill,mis} got %b want 100000",
               {bif.br_ready, rv, fl, br_un, ill, mis});
    end
    total++;
    if ({tcnt, rpc} !== '0) begin
      bad++;
      $display("FAIL reset regs: count %0d pc %h want 0 0", tcnt, rpc);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_branches();
    issue("beq_taken",  F3_BEQ,  1'b0, 1'b0, 32'h100, 32'h0, 32'h20, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    issue("bne_eq",     F3_BNE,  1'b0, 1'b0, 32'h140, 32'h0, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    issue("bltu_lt",    F3_BLTU, 1'b0, 1'b0, 32'h180, 32'h0, 32'hFFFF_FFF0, 1'b0, 1'b1,
          1'b1, 1'b1, 1'b0);
    issue("bge_nlt",    F3_BGE,  1'b0, 1'b0, 32'h200, 32'h0, 32'h10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    issue("blt_nlt",    F3_BLT,  1'b0, 1'b0, 32'h220, 32'h0, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue("bgeu_lt",    F3_BGEU, 1'b0, 1'b0, 32'h240, 32'h0, 32'h10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    issue("beq_misal",  F3_BEQ,  1'b0, 1'b0, 32'h100, 32'h0, 32'h6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    issue("bne_wrap",   F3_BNE,  1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h8, 1'b0, 1'b0,
          1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_jumps();
    issue("jalr_even",  3'b000, 1'b1, 1'b1, 32'h500, 32'h1001, 32'h4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    issue("jalr_misal", 3'b000, 1'b1, 1'b1, 32'h500, 32'h1001, 32'h1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    issue("jal",        3'b110, 1'b1, 1'b0, 32'h200, 32'h0, 32'h8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    issue("jal_f3_011", 3'b011, 1'b1, 1'b0, 32'h300, 32'h0, 32'h2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_illegal();
    issue("illegal_010", 3'b010, 1'b0, 1'b0, 32'h400, 32'h0, 32'h10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    issue("illegal_011", 3'b011, 1'b0, 1'b0, 32'h400, 32'h0, 32'h10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      issue("b2b", F3_BEQ, 1'b0, 1'b0, 32'h1000 + 32'(i * 16), 32'h0, 32'h40,
            i[0], 1'b0, i[0], 1'b0, 1'b0);
    end
  endtask

  // A second request held during a busy transaction must be ignored.
  task automatic test_busy();
    logic ok;
    exp_t e;
    exp_t got;
    wait_ready("busy", ok);
    if (!ok) return;
    bif.br_funct3 = 3'b000; bif.br_is_jump = 1'b1; bif.br_base_sel = 1'b0;
    bif.br_pc = 32'h300; bif.br_imm = 32'h10; bif.br_valid = 1'b1;
    e.pc = 32'h310; e.mis = 1'b0;
    sb_q.push_back(e);
    @(posedge clk);
    #1 begin bif.br_pc = 32'h500; bif.br_imm = 32'h0; end
    @(negedge clk);
    total++;
    if (bif.br_ready !== 1'b0) begin
      bad++;
      $display("FAIL busy ready: got %b want 0", bif.br_ready);
    end
    @(negedge clk);
    total++;
    if (rv !== 1'b1 || sb_q.size() == 0) begin
      bad++;
      $display("FAIL busy redirect: rv got %b want 1 (queue %0d)", rv, sb_q.size());
    end else begin
      got = sb_q.pop_front();
      total++;
      if (rpc !== got.pc) begin
        bad++;
        $display("FAIL busy target: got %h want %h", rpc, got.pc);
      end
      last_pc = got.pc;
    end
    bif.br_valid = 1'b0;
    cnt_model++;
    repeat (FC + 1) @(negedge clk);
    total++;
    if ({bif.br_ready, tcnt} !== {1'b1, CW'(cnt_model)}) begin
      bad++;
      $display("FAIL busy end: ready/count got %b/%0d want 1/%0d", bif.br_ready, tcnt,
               cnt_model);
    end
  endtask

  task automatic test_reset_mid_flush();
    logic ok;
    wait_ready("rst_flush", ok);
    if (!ok) return;
    bif.br_funct3 = F3_BEQ; bif.br_is_jump = 1'b0; bif.br_base_sel = 1'b0;
    bif.br_pc = 32'h700; bif.br_imm = 32'h40; br_eq = 1'b1; bif.br_valid = 1'b1;
    @(posedge clk);
    #1 bif.br_valid = 1'b0;
    repeat (3) @(negedge clk);  // first FLUSH cycle
    total++;
    if ({fl, bif.br_ready} !== 2'b10) begin
      bad++;
      $display("FAIL rst_flush pre: {flush,ready} got %b want 10", {fl, bif.br_ready});
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({fl, bif.br_ready, rv, tcnt} !== {3'b010, CW'(0)}) begin
      bad++;
      $display("FAIL rst_flush async: {flush,ready,rv} %b count %0d want 010 0",
               {fl, bif.br_ready, rv}, tcnt);
    end
    cnt_model = 0;
    last_pc   = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue("after_rst", 3'b000, 1'b1, 1'b0, 32'h200, 32'h0, 32'h8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // 2-bit counter saturates at 3; with no FLUSH state ready returns right after REDIRECT.
  task automatic test_saturate();
    exp_t e;
    exp_t got;
    int   n;
    for (int i = 0; i < 5; i++) begin
      n = 0;
      while (bif2.br_ready !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      bif2.br_funct3 = 3'b000; bif2.br_is_jump = 1'b1; bif2.br_base_sel = 1'b0;
      bif2.br_pc = 32'(32'h40 * (i + 1)); bif2.br_imm = 32'h8; bif2.br_valid = 1'b1;
      e.pc = 32'(32'h40 * (i + 1)) + 32'h8;
      e.mis = 1'b0;
      sb_q.push_back(e);
      @(posedge clk);
      #1 bif2.br_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      total++;
      if (rv2 !== 1'b1 || sb_q.size() == 0) begin
        bad++;
        $display("FAIL sat%0d redirect: rv got %b want 1", i, rv2);
      end else begin
        got = sb_q.pop_front();
        total++;
        if ({rpc2, mis2} !== {got.pc, got.mis}) begin
          bad++;
          $display("FAIL sat%0d target: got %h/%b want %h/%b", i, rpc2, mis2, got.pc, got.mis);
        end
      end
      @(negedge clk);
      total++;
      if ({bif2.br_ready, fl2, tcnt2} !== {2'b10, ((i + 1) > 3) ? 2'd3 : 2'(i + 1)}) begin
        bad++;
        $display("FAIL sat%0d end: {ready,flush} %b count %0d want 10 %0d", i,
                 {bif2.br_ready, fl2}, tcnt2, ((i + 1) > 3) ? 3 : i + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_branches();
    test_jumps();
    test_illegal();
    test_back_to_back();
    test_busy();
    test_reset_mid_flush();
    test_saturate();
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard drain: %0d entries left, want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
